// File: rtl/cmac_csb_pkg.sv
// Shared definitions for the CMAC CSB register initiator.
// Covers the CSB request/response packet layout, the FSM states and the byte-offset shift.
package cmac_csb_pkg;

    localparam int unsigned ReqWidth       = 63;
    localparam int unsigned ReqAddrLsb     = 0;
    localparam int unsigned ReqAddrMsb     = 21;
    localparam int unsigned ReqWdatLsb     = 22;
    localparam int unsigned ReqWdatMsb     = 53;
    localparam int unsigned ReqWriteBit    = 54;
    localparam int unsigned ReqNpostedBit  = 55;
    localparam int unsigned ReqSrcprivBit  = 56;
    localparam int unsigned ReqWrbeLsb     = 57;
    localparam int unsigned ReqWrbeMsb     = 60;
    localparam int unsigned ReqLevelLsb    = 61;
    localparam int unsigned ReqLevelMsb    = 62;

    localparam int unsigned RespWidth       = 34;
    localparam int unsigned RespRdatMsb     = 31;
    localparam int unsigned RespErrorBit    = 32;
    localparam int unsigned RespWriteAckBit = 33;
    localparam logic        RespIsWriteAck  = 1'b1;
    localparam logic        RespIsReadData  = 1'b0;

    localparam int unsigned DataWidth      = 32;
    localparam int unsigned OffsetWidth    = 12;
    localparam int unsigned OffsetAddrBits = 10;
    localparam int unsigned OffsetShift    = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } csb_state_e;

    // The error bit is never raised by this slice.
    function automatic logic [RespWidth-1:0] make_resp(input logic                 is_write_ack,
                                                       input logic [DataWidth-1:0] rdat);
        logic [RespWidth-1:0] pd;
        pd                  = '0;
        pd[RespRdatMsb:0]   = rdat;
        pd[RespErrorBit]    = 1'b0;
        pd[RespWriteAckBit] = is_write_ack;
        return pd;
    endfunction

endpackage

// File: rtl/cmac_csb_reg_initiator.sv
// Converts one CSB request at a time into a single-cycle register access on the CMAC
// responders and returns the CSB response two cycles after acceptance.
module cmac_csb_reg_initiator
    import cmac_csb_pkg::*;
(
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic                   csb2cmac_req_pvld,
    output logic                   csb2cmac_req_prdy,
    input  logic [ReqWidth-1:0]    csb2cmac_req_pd,
    output logic                   cmac2csb_resp_valid,
    output logic [RespWidth-1:0]   cmac2csb_resp_pd,
    output logic [OffsetWidth-1:0] reg_offset,
    output logic [DataWidth-1:0]   reg_wr_data,
    output logic                   reg_wr_en,
    input  logic [DataWidth-1:0]   reg_rd_data
);

    csb_state_e             state_q, state_d;
    logic [OffsetWidth-1:0] reg_offset_q, reg_offset_d;
    logic [DataWidth-1:0]   reg_wr_data_q, reg_wr_data_d;
    logic                   write_q, write_d;
    logic                   nposted_q, nposted_d;
    logic [DataWidth-1:0]   rdat_q, rdat_d;
    logic                   accept;

    // Routing bits, byte enables, privilege and level carry no meaning here.
    logic unused_req_fields;
    assign unused_req_fields = ^{csb2cmac_req_pd[ReqAddrMsb:OffsetAddrBits],
                                 csb2cmac_req_pd[ReqLevelMsb:ReqLevelLsb],
                                 csb2cmac_req_pd[ReqWrbeMsb:ReqWrbeLsb],
                                 csb2cmac_req_pd[ReqSrcprivBit]};

    assign accept = (state_q == StIdle) && csb2cmac_req_pvld;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (csb2cmac_req_pvld) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            reg_offset_q  <= '0;
            reg_wr_data_q <= '0;
            write_q       <= 1'b0;
            nposted_q     <= 1'b0;
            rdat_q        <= '0;
        end else begin
            reg_offset_q  <= reg_offset_d;
            reg_wr_data_q <= reg_wr_data_d;
            write_q       <= write_d;
            nposted_q     <= nposted_d;
            rdat_q        <= rdat_d;
        end
    end

    always_comb begin
        reg_offset_d  = reg_offset_q;
        reg_wr_data_d = reg_wr_data_q;
        write_d       = write_q;
        nposted_d     = nposted_q;
        rdat_d        = rdat_q;
        if (accept) begin
            reg_offset_d  = OffsetWidth'(csb2cmac_req_pd[OffsetAddrBits-1:0]) << OffsetShift;
            reg_wr_data_d = csb2cmac_req_pd[ReqWdatMsb:ReqWdatLsb];
            write_d       = csb2cmac_req_pd[ReqWriteBit];
            nposted_d     = csb2cmac_req_pd[ReqNpostedBit];
        end
        // Responder read data is only meaningful while the offset is presented.
        if ((state_q == StAccess) && !write_q) begin
            rdat_d = reg_rd_data;
        end
    end

    always_comb begin
        csb2cmac_req_prdy   = (state_q == StIdle);
        reg_offset          = reg_offset_q;
        reg_wr_data         = reg_wr_data_q;
        reg_wr_en           = (state_q == StAccess) && write_q;
        cmac2csb_resp_valid = (state_q == StResp) && (!write_q || nposted_q);
        cmac2csb_resp_pd    = '0;
        if (cmac2csb_resp_valid) begin
            cmac2csb_resp_pd = write_q ? make_resp(RespIsWriteAck, '0)
                                       : make_resp(RespIsReadData, rdat_q);
        end
    end

endmodule

// File: tb/tb_cmac_csb_reg_initiator.sv
// Bench for cmac_csb_reg_initiator: directed requests against a small register responder,
// a transaction-level model checked every cycle, and literal expectations per request.
module tb_cmac_csb_reg_initiator;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rsp_rstn = 1'b0;
    logic        pvld = 1'b0;
    logic [62:0] req_pd = '0;
    logic        prdy;
    logic        resp_valid;
    logic [33:0] resp_pd;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic [31:0] reg_rd_data;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] J = 7'b00_1111_0; // level=0, wrbe=f, srcpriv=0

    cmac_csb_reg_initiator dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rstn     (rstn),
        .csb2cmac_req_pvld   (pvld),
        .csb2cmac_req_prdy   (prdy),
        .csb2cmac_req_pd     (req_pd),
        .cmac2csb_resp_valid (resp_valid),
        .cmac2csb_resp_pd    (resp_pd),
        .reg_offset          (reg_offset),
        .reg_wr_data         (reg_wr_data),
        .reg_wr_en           (reg_wr_en),
        .reg_rd_data         (reg_rd_data)
    );

    always #5 clk = ~clk;

    // Responder: op_en at byte 0x008, conv_mode[0] / proc_precision[13:12] at byte 0x00C.
    logic       rsp_op_en;
    logic       rsp_conv;
    logic [1:0] rsp_prec;

    always_ff @(posedge clk or negedge rsp_rstn) begin
        if (!rsp_rstn) begin
            rsp_op_en <= 1'b0;
            rsp_conv  <= 1'b0;
            rsp_prec  <= 2'b01;
        end else if (reg_wr_en) begin
            if (reg_offset == 12'h008) rsp_op_en <= reg_wr_data[0];
            if (reg_offset == 12'h00C) begin
                rsp_conv <= reg_wr_data[0];
                rsp_prec <= reg_wr_data[13:12];
            end
        end
    end

    always_comb begin
        reg_rd_data = '0;
        if (reg_offset == 12'h008) reg_rd_data = {31'b0, rsp_op_en};
        if (reg_offset == 12'h00C) reg_rd_data = {18'b0, rsp_prec, 11'b0, rsp_conv};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [62:0] mk(input logic [21:0] addr, input logic [31:0] wdat,
                                       input logic wr, input logic np, input logic [6:0] junk);
        return {junk, np, wr, wdat, addr};
    endfunction

    // Model: an accepted request occupies the edge it is accepted on plus two more cycles.
    int          edge_n = 0;
    int          acc_edge = -100;
    logic [11:0] m_off = '0;
    logic [31:0] m_wdat = '0;
    logic [31:0] m_rdat = '0;
    logic        m_write = 1'b0;
    logic        m_np = 1'b0;
    logic        m_op_en = 1'b0;
    logic        m_conv = 1'b0;
    logic [1:0]  m_prec = 2'b01;

    function automatic logic [31:0] m_read(input logic [11:0] off);
        if (off == 12'h008) return {31'b0, m_op_en};
        if (off == 12'h00C) return {18'b0, m_prec, 11'b0, m_conv};
        return 32'h0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            acc_edge = -100;
            m_off    = '0;
            m_wdat   = '0;
        end else begin
            edge_n++;
            if (edge_n == acc_edge + 1 && m_write) begin
                if (m_off == 12'h008) m_op_en = m_wdat[0];
                if (m_off == 12'h00C) begin
                    m_conv = m_wdat[0];
                    m_prec = m_wdat[13:12];
                end
            end
            if (pvld && edge_n >= acc_edge + 3) begin
                acc_edge = edge_n;
                m_off    = 12'((req_pd[21:0] * 4) % 4096);
                m_wdat   = req_pd[53:22];
                m_write  = req_pd[54];
                m_np     = req_pd[55];
                m_rdat   = m_read(m_off);
            end
        end
    end

    logic [33:0] resp_q[$];
    logic        in_acc, in_resp, e_valid;
    logic [33:0] e_pd;

    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            chk("rst_wr_en", {63'b0, reg_wr_en}, 64'd0);
            chk("rst_offset", {52'b0, reg_offset}, 64'd0);
            chk("rst_wr_data", {32'b0, reg_wr_data}, 64'd0);
            chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
            chk("rst_resp_pd", {30'b0, resp_pd}, 64'd0);
        end else begin
            in_acc  = (edge_n == acc_edge);
            in_resp = (edge_n == acc_edge + 1);
            e_valid = in_resp && (!m_write || m_np);
            e_pd    = !e_valid ? 34'h0 : (m_write ? (34'd1 << 33) : {2'b00, m_rdat});
            chk("m_prdy", {63'b0, prdy}, {63'b0, !(in_acc || in_resp)});
            chk("m_wr_en", {63'b0, reg_wr_en}, {63'b0, in_acc && m_write});
            chk("m_offset", {52'b0, reg_offset}, {52'b0, m_off});
            chk("m_wr_data", {32'b0, reg_wr_data}, {32'b0, m_wdat});
            chk("m_resp_valid", {63'b0, resp_valid}, {63'b0, e_valid});
            if (!in_resp || e_valid) chk("m_resp_pd", {30'b0, resp_pd}, {30'b0, e_pd});
            if (resp_valid) resp_q.push_back(resp_pd);
        end
    end

    task automatic do_req(input string nm, input logic [62:0] pd, input logic [11:0] e_off,
                          input logic e_wr, input logic e_vld, input logic [33:0] e_pd);
        pvld   = 1'b1;
        req_pd = pd;
        @(posedge clk); #1;
        pvld = 1'b0;
        chk({nm, "_offset"}, {52'b0, reg_offset}, {52'b0, e_off});
        chk({nm, "_wr_en"}, {63'b0, reg_wr_en}, {63'b0, e_wr});
        @(posedge clk); #1;
        chk({nm, "_resp_valid"}, {63'b0, resp_valid}, {63'b0, e_vld});
        if (e_vld) chk({nm, "_resp_pd"}, {30'b0, resp_pd}, {30'b0, e_pd});
        @(posedge clk); #1;
        chk({nm, "_prdy"}, {63'b0, prdy}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rstn     = 1'b1;
        rsp_rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_prdy", {63'b0, prdy}, 64'd1);

        do_req("rd_prec_rst", mk(22'h1C03, 32'h0, 1'b0, 1'b0, J), 12'h00C, 1'b0, 1'b1,
               34'h0_0000_1000);
        do_req("wr_np", mk(22'h1C03, 32'h0000_3001, 1'b1, 1'b1, J), 12'h00C, 1'b1, 1'b1,
               34'h2_0000_0000);
        chk("conv_mode", {63'b0, rsp_conv}, 64'd1);
        chk("proc_precision", {62'b0, rsp_prec}, 64'd3);
        do_req("wr_posted", mk(22'h1C02, 32'h1, 1'b1, 1'b0, J), 12'h008, 1'b1, 1'b0, 34'h0);
        chk("op_en", {63'b0, rsp_op_en}, 64'd1);
        do_req("rd_op_en", mk(22'h1C02, 32'h0, 1'b0, 1'b0, J), 12'h008, 1'b0, 1'b1,
               34'h0_0000_0001);
        do_req("rd_unknown", mk(22'h1C3F, 32'hDEAD_BEEF, 1'b0, 1'b1, 7'b10_1010_1), 12'h0FC,
               1'b0, 1'b1, 34'h0);
        // High address bits set and a partial byte enable: still a full-word write.
        do_req("wr_partial", mk(22'h3FFC03, 32'h0000_2001, 1'b1, 1'b1, 7'b11_0001_1), 12'h00C,
               1'b1, 1'b1, 34'h2_0000_0000);
        chk("partial_prec", {62'b0, rsp_prec}, 64'd2);

        resp_q.delete();
        pvld   = 1'b1;
        req_pd = mk(22'h1C02, 32'h0, 1'b0, 1'b0, J);
        @(posedge clk); #1;
        req_pd = mk(22'h1C03, 32'h0, 1'b0, 1'b0, J);
        repeat (3) @(posedge clk);
        #1;
        req_pd = mk(22'h1C3F, 32'h0, 1'b0, 1'b0, J);
        repeat (3) @(posedge clk);
        #1;
        pvld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_count", 64'(resp_q.size()), 64'd3);
        if (resp_q.size() == 3) begin
            chk("b2b_resp0", {30'b0, resp_q[0]}, 64'h1);
            chk("b2b_resp1", {30'b0, resp_q[1]}, 64'h2001);
            chk("b2b_resp2", {30'b0, resp_q[2]}, 64'h0);
        end

        resp_q.delete();
        pvld   = 1'b1;
        req_pd = mk(22'h1C03, 32'h0, 1'b1, 1'b1, J);
        @(posedge clk); #1;
        pvld = 1'b0;
        chk("rst_acc_wr_en", {63'b0, reg_wr_en}, 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_wr_en_drop", {63'b0, reg_wr_en}, 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_prdy", {63'b0, prdy}, 64'd1);
        chk("rst_no_resp", 64'(resp_q.size()), 64'd0);
        chk("rst_conv_kept", {63'b0, rsp_conv}, 64'd1);
        chk("rst_prec_kept", {62'b0, rsp_prec}, 64'd2);
        do_req("rd_after_rst", mk(22'h1C03, 32'h0, 1'b0, 1'b0, J), 12'h00C, 1'b0, 1'b1,
               34'h0_0000_2001);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
